// File: rtl/ext_pkg.sv
// Shared widths and extension opcodes for the immediate extender.
// EOp encoding: SIGN, ZERO, LUI and BOFS (branch offset) forms.
package ext_pkg;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        EOP_SIGN = 2'd0,
        EOP_ZERO = 2'd1,
        EOP_LUI  = 2'd2,
        EOP_BOFS = 2'd3
    } eop_t;

endpackage

// File: rtl/imm_ext_if.sv
// Immediate/opcode request bus and extended-immediate result.
// Master drives imm/EOp, slave returns ext.
interface imm_ext_if;
    import ext_pkg::*;

    logic [IMM_W-1:0]  imm;
    logic [1:0]        EOp;
    logic [DATA_W-1:0] ext;

    modport master (
        output imm,
        output EOp,
        input  ext
    );

    modport slave (
        input  imm,
        input  EOp,
        output ext
    );

endinterface

// File: rtl/ext_core.sv
// Combinational selection of the four immediate forms.
// Any unexpected opcode falls back to sign extension.
module ext_core
    import ext_pkg::*;
(
    input  logic [IMM_W-1:0]  imm_i,
    input  eop_t              eop_i,
    output logic [DATA_W-1:0] ext_o
);

    // Pick the extension form requested by the controller
    always_comb begin
        ext_o = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        case (eop_i)
            EOP_SIGN: ext_o = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
            EOP_ZERO: ext_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
            EOP_LUI:  ext_o = {imm_i, {(DATA_W-IMM_W){1'b0}}};
            EOP_BOFS: ext_o = {{(DATA_W-IMM_W-2){imm_i[IMM_W-1]}},
                               imm_i, 2'b00};
            default:  ext_o = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        endcase
    end

endmodule

// File: rtl/imm_ext.sv
// 16-to-32-bit immediate extender at the decode/execute boundary.
// Define EXT_REG_OUT_EN to register ext (async reset to 0).
module imm_ext
    import ext_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    imm_ext_if.slave  bus
);

    logic [DATA_W-1:0] core_ext;

    ext_core u_core (
        .imm_i (bus.imm),
        .eop_i (eop_t'(bus.EOp)),
        .ext_o (core_ext)
    );

`ifdef EXT_REG_OUT_EN
    logic [DATA_W-1:0] ext_d;
    logic [DATA_W-1:0] ext_q;

    assign ext_d = core_ext;

    // Output register breaks the path into the ALU operand mux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= '0;
        end else begin
            ext_q <= ext_d;
        end
    end

    assign bus.ext = ext_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign bus.ext        = core_ext;
`endif

endmodule

// File: tb/tb_imm_ext.sv
// Self-checking bench for imm_ext, both output modes.
// Reference model evaluates the extension rules arithmetically.
module tb_imm_ext;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    imm_ext_if bus_if ();

    imm_ext dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm,
                                            input logic [1:0]  op);
        longint u;
        longint s;
        longint r;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (op)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = u * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic apply(input logic [15:0] imm, input logic [1:0] op);
`ifdef EXT_REG_OUT_EN
        @(negedge clk);
        bus_if.imm = imm;
        bus_if.EOp = op;
        @(posedge clk);
        #1;
`else
        bus_if.imm = imm;
        bus_if.EOp = op;
        #1;
`endif
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus_if.imm = 16'hF3D4;
        bus_if.EOp = 2'd0;
        #1;
`ifdef EXT_REG_OUT_EN
        checks++;
        if (bus_if.ext !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", bus_if.ext, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.ext !== 32'h0) begin
            failures++;
            $display("FAIL reset_edge got=%h exp=%h", bus_if.ext, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_if.ext !== 32'h0) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", bus_if.ext, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.ext !== 32'hFFFF_F3D4) begin
            failures++;
            $display("FAIL reset_first_edge got=%h exp=%h",
                     bus_if.ext, 32'hFFFF_F3D4);
        end
`else
        checks++;
        if (bus_if.ext !== 32'hFFFF_F3D4) begin
            failures++;
            $display("FAIL reset_ignored got=%h exp=%h",
                     bus_if.ext, 32'hFFFF_F3D4);
        end
        rst_n = 1'b1;
        #1;
`endif
    endtask

    task automatic test_vectors();
        logic [15:0] vi [10];
        logic [1:0]  vo [10];
        logic [31:0] ve [10];
        vi = '{16'hF3D4, 16'hF3D4, 16'hF3D4, 16'hF3D4, 16'h7FFF,
               16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vo = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
               2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
        ve = '{32'hFFFF_F3D4, 32'h0000_F3D4, 32'hF3D4_0000, 32'hFFFF_CF50,
               32'h0000_7FFF, 32'h0001_FFFC, 32'hFFFF_8000, 32'h0000_8000,
               32'hFFFE_0000, 32'h8000_0000};
        for (int i = 0; i < 10; i++) begin
            apply(vi[i], vo[i]);
            checks++;
            if (bus_if.ext !== ve[i]) begin
                failures++;
                $display("FAIL vec%0d imm=%h op=%0d got=%h exp=%h",
                         i, vi[i], vo[i], bus_if.ext, ve[i]);
            end
        end
    endtask

    task automatic test_hold();
`ifdef EXT_REG_OUT_EN
        apply(16'h00A5, 2'd1);
        bus_if.imm = 16'hFFFF;
        bus_if.EOp = 2'd2;
        @(negedge clk);
        checks++;
        if (bus_if.ext !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL hold_between_edges got=%h exp=%h",
                     bus_if.ext, 32'h0000_00A5);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.ext !== 32'hFFFF_0000) begin
            failures++;
            $display("FAIL hold_next_edge got=%h exp=%h",
                     bus_if.ext, 32'hFFFF_0000);
        end
`else
        apply(16'h00A5, 2'd1);
        checks++;
        if (bus_if.ext !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL comb_settle got=%h exp=%h",
                     bus_if.ext, 32'h0000_00A5);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        apply(16'h1234, 2'd2);
        checks++;
        if (bus_if.ext !== 32'h1234_0000) begin
            failures++;
            $display("FAIL mid_pre got=%h exp=%h", bus_if.ext, 32'h1234_0000);
        end
        #1;
        rst_n = 1'b0;
        #1;
`ifdef EXT_REG_OUT_EN
        checks++;
        if (bus_if.ext !== 32'h0) begin
            failures++;
            $display("FAIL mid_async_clear got=%h exp=%h", bus_if.ext, 32'h0);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_if.ext !== 32'h0) begin
            failures++;
            $display("FAIL mid_release_hold got=%h exp=%h", bus_if.ext, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.ext !== 32'h1234_0000) begin
            failures++;
            $display("FAIL mid_first_edge got=%h exp=%h",
                     bus_if.ext, 32'h1234_0000);
        end
`else
        checks++;
        if (bus_if.ext !== 32'h1234_0000) begin
            failures++;
            $display("FAIL mid_comb_unaffected got=%h exp=%h",
                     bus_if.ext, 32'h1234_0000);
        end
        rst_n = 1'b1;
        #1;
`endif
    endtask

    task automatic test_random();
        logic [15:0] ri;
        logic [1:0]  ro;
        logic [31:0] exp;
        int          bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ri  = 16'($urandom);
            ro  = 2'($urandom_range(3, 0));
            exp = ref_ext(ri, ro);
            apply(ri, ro);
            checks++;
            if (bus_if.ext !== exp) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand%0d imm=%h op=%0d got=%h exp=%h",
                             i, ri, ro, bus_if.ext, exp);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus_if.imm = '0;
        bus_if.EOp = '0;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
